// File: rtl/psg_seq_pkg.sv
// Shared types and helpers for the PSG command player.
//   state_t  - sequencer state encoding
//   cmd_t    - one queued command {chip, reg_num, val, wait_cnt}, sized for
//              the largest legal configuration (8 chips, 32-bit wait)
//   chip_w() - width of the chip index for a given chip count
//   level_w()- width of the FIFO occupancy count for a given depth
package psg_seq_pkg;

  localparam int CHIP_MAX_W = 3;
  localparam int WAIT_MAX_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_A_WR  = 3'd2,
    S_A_GAP = 3'd3,
    S_D_WR  = 3'd4,
    S_D_GAP = 3'd5
  } state_t;

  typedef struct packed {
    logic [CHIP_MAX_W-1:0] chip;
    logic [7:0]            reg_num;
    logic [7:0]            val;
    logic [WAIT_MAX_W-1:0] wait_cnt;
  } cmd_t;

  function automatic int chip_w(input int nchip);
    return (nchip > 1) ? $clog2(nchip) : 1;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO. flush empties it on the same edge and takes
// priority over push and pop. Reads are from the registered array at rd_ptr.
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   push, din          - write a command (ignored when full or flushing)
//   pop                - drop the head entry (ignored when empty or flushing)
//   flush              - discard all entries
//   dout               - head entry
//   full, empty, level - occupancy status, level counts 0..DEPTH
module psg_cmd_fifo
  import psg_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  cmd_t          din,
  input  logic          pop,
  input  logic          flush,
  output cmd_t          dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psg_cmd_player.sv
// Timed register-write sequencer for jt03-class chips on a shared bus.
// Each queued command waits cmd_wait cen ticks, then performs an address
// write (addr=0, dout=reg) followed by a data write (addr=1, dout=val) with
// the target chip selected for the whole pair.
// Ports:
//   clk, rst_n, cen              - clock, async active-low reset, wait tick
//   cmd_valid/cmd_ready, cmd_*   - command push handshake and fields
//   flush                        - discard queued commands / abort a wait
//   cs_n, wr_n, addr, dout       - chip bus (all registered)
//   busy, level, err_chip        - status
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no command in progress, pop when FIFO non-empty
// S_WAIT  | counting down cmd_wait cen ticks
// S_A_WR  | address write, wr_n low for WR_LEN clocks
// S_A_GAP | wr_n high for GAP_LEN clocks
// S_D_WR  | data write, wr_n low for WR_LEN clocks
// S_D_GAP | wr_n high for GAP_LEN clocks, then back to idle
module psg_cmd_player
  import psg_seq_pkg::*;
#(
  parameter int NCHIP   = 2,
  parameter int DEPTH   = 8,
  parameter int WAIT_W  = 16,
  parameter int WR_LEN  = 1,
  parameter int GAP_LEN = 1,
  parameter int CW      = chip_w(NCHIP),
  parameter int LW      = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     cmd_chip,
  input  logic [7:0]        cmd_reg,
  input  logic [7:0]        cmd_val,
  input  logic [WAIT_W-1:0] cmd_wait,
  input  logic              flush,
  output logic [NCHIP-1:0]  cs_n,
  output logic              wr_n,
  output logic              addr,
  output logic [7:0]        dout,
  output logic              busy,
  output logic [LW-1:0]     level,
  output logic              err_chip
);

  localparam int PH_MAX = (WR_LEN > GAP_LEN) ? WR_LEN : GAP_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] WR_LOAD  = PH_W'(WR_LEN - 1);
  localparam logic [PH_W-1:0] GAP_LOAD = PH_W'(GAP_LEN - 1);

  cmd_t                  cmd_in;
  cmd_t                  fifo_q;
  state_t                state;
  logic [CHIP_MAX_W-1:0] cur_chip;
  logic [7:0]            cur_reg;
  logic [7:0]            cur_val;
  logic [WAIT_MAX_W-1:0] wait_cnt;
  logic [PH_W-1:0]       ph_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  chip_ok;
  logic                  push;
  logic                  pop;
  logic                  bus_active;
  logic                  data_phase;

  assign cmd_ready = !fifo_full && !flush;
  assign chip_ok   = int'(cmd_chip) < NCHIP;
  // Out-of-range chip commands are handshaken but never stored.
  assign push      = cmd_valid && cmd_ready && chip_ok;
  assign pop       = (state == S_IDLE) && !fifo_empty && !flush;

  always_comb begin
    cmd_in          = '0;
    cmd_in.chip     = CHIP_MAX_W'(cmd_chip);
    cmd_in.reg_num  = cmd_reg;
    cmd_in.val      = cmd_val;
    cmd_in.wait_cnt = WAIT_MAX_W'(cmd_wait);
  end

  always_comb begin
    bus_active = state inside {S_A_WR, S_A_GAP, S_D_WR, S_D_GAP};
    data_phase = state inside {S_D_WR, S_D_GAP};
  end

  psg_cmd_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_chip <= 1'b0;
    else if (cmd_valid && cmd_ready && !chip_ok) err_chip <= 1'b1;
  end

  // flush only aborts a pending wait; once the address phase has started the
  // data phase always follows so the chip never sees a dangling address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_chip <= '0;
      cur_reg  <= '0;
      cur_val  <= '0;
      wait_cnt <= '0;
      ph_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_chip <= fifo_q.chip;
            cur_reg  <= fifo_q.reg_num;
            cur_val  <= fifo_q.val;
            if (fifo_q.wait_cnt != '0) begin
              wait_cnt <= fifo_q.wait_cnt;
              state    <= S_WAIT;
            end else begin
              ph_cnt <= WR_LOAD;
              state  <= S_A_WR;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cen) begin
            if (wait_cnt == WAIT_MAX_W'(1)) begin
              ph_cnt <= WR_LOAD;
              state  <= S_A_WR;
            end else begin
              wait_cnt <= wait_cnt - WAIT_MAX_W'(1);
            end
          end
        end
        S_A_WR: begin
          if (ph_cnt == '0) begin
            ph_cnt <= GAP_LOAD;
            state  <= S_A_GAP;
          end else ph_cnt <= ph_cnt - PH_W'(1);
        end
        S_A_GAP: begin
          if (ph_cnt == '0) begin
            ph_cnt <= WR_LOAD;
            state  <= S_D_WR;
          end else ph_cnt <= ph_cnt - PH_W'(1);
        end
        S_D_WR: begin
          if (ph_cnt == '0) begin
            ph_cnt <= GAP_LOAD;
            state  <= S_D_GAP;
          end else ph_cnt <= ph_cnt - PH_W'(1);
        end
        S_D_GAP: begin
          if (ph_cnt == '0) state <= S_IDLE;
          else ph_cnt <= ph_cnt - PH_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are registered from the current state, so they trail the
  // state by one clock; addr/dout keep their last values outside a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n <= '1;
      wr_n <= 1'b1;
      addr <= 1'b0;
      dout <= '0;
      busy <= 1'b0;
    end else begin
      busy <= (state != S_IDLE);
      wr_n <= !(state == S_A_WR || state == S_D_WR);
      for (int i = 0; i < NCHIP; i++) begin
        cs_n[i] <= !(bus_active && (cur_chip == CHIP_MAX_W'(i)));
      end
      if (bus_active) begin
        addr <= data_phase;
        dout <= data_phase ? cur_val : cur_reg;
      end
    end
  end

endmodule

// File: tb/tb_psg_cmd_player.sv
// Self-checking bench for psg_cmd_player. Three chips are used so that an
// out-of-range chip index (3) is representable on cmd_chip.
module tb_psg_cmd_player;

  localparam int NCHIP   = 3;
  localparam int DEPTH   = 8;
  localparam int WAIT_W  = 16;
  localparam int WR_LEN  = 1;
  localparam int GAP_LEN = 1;
  localparam int CW      = 2;
  localparam int LW      = 4;
  localparam int PAIR    = 2 * (WR_LEN + GAP_LEN);
  localparam int PERIOD  = PAIR + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cen = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CW-1:0]     cmd_chip = '0;
  logic [7:0]        cmd_reg = '0;
  logic [7:0]        cmd_val = '0;
  logic [WAIT_W-1:0] cmd_wait = '0;
  logic              flush = 1'b0;
  logic [NCHIP-1:0]  cs_n;
  logic              wr_n;
  logic              addr;
  logic [7:0]        dout;
  logic              busy;
  logic [LW-1:0]     level;
  logic              err_chip;

  psg_cmd_player #(
    .NCHIP(NCHIP), .DEPTH(DEPTH), .WAIT_W(WAIT_W),
    .WR_LEN(WR_LEN), .GAP_LEN(GAP_LEN), .CW(CW), .LW(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chip(cmd_chip),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val), .cmd_wait(cmd_wait), .flush(flush),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout),
    .busy(busy), .level(level), .err_chip(err_chip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         chip;
    logic       a;
    logic [7:0] d;
  } ev_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   cyc = 0;
  int   cen_per = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_wr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int low_chip(input logic [NCHIP-1:0] c);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < NCHIP; i++) if (c[i] == 1'b0) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  // Every falling edge of wr_n is one bus write.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n && wr_n == 1'b0 && prev_wr == 1'b1) begin
      e.cyc = cyc; e.chip = low_chip(cs_n); e.a = addr; e.d = dout;
      obs_q.push_back(e);
    end
    prev_wr = wr_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cen = (cen_per != 0) && ((cyc % cen_per) == 0);
  endtask

  // Reference model: an accepted, in-range command yields an address write
  // of reg then a data write of val to its chip.
  task automatic push_cmd(input int chip, input logic [7:0] r, input logic [7:0] v,
                          input int w, output bit acc);
    ev_t e;
    cmd_valid = 1'b1; cmd_chip = CW'(chip); cmd_reg = r; cmd_val = v;
    cmd_wait = WAIT_W'(w);
    acc = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    if (acc && chip < NCHIP) begin
      e.cyc = 0; e.chip = chip; e.a = 1'b0; e.d = r; exp_q.push_back(e);
      e.a = 1'b1; e.d = v; exp_q.push_back(e);
    end
  endtask

  task automatic wait_events(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; cen = 1'b0;
    #12;
    n_checks += 8;
    if (cs_n !== '1)       begin n_fail++; $display("FAIL reset_cs_n: got %b expected all ones", cs_n); end
    if (wr_n !== 1'b1)     begin n_fail++; $display("FAIL reset_wr_n: got %b expected 1", wr_n); end
    if (addr !== 1'b0)     begin n_fail++; $display("FAIL reset_addr: got %b expected 0", addr); end
    if (dout !== 8'h00)    begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (level !== '0)      begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    if (err_chip !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_chip); end
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single();
    bit acc;
    int n0, k;
    logic a_lo, d_lo, act;
    logic [NCHIP-1:0] exp_cs;
    cen_per = 0;
    push_cmd(0, 8'h07, 8'h38, 0, acc);
    n0 = cyc;
    n_checks++;
    if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
    for (int s = 0; s < 7; s++) begin
      tick();
      k = cyc - n0;
      a_lo = (k >= 2) && (k < 2 + WR_LEN);
      d_lo = (k >= 2 + WR_LEN + GAP_LEN) && (k < 2 + 2 * WR_LEN + GAP_LEN);
      act  = (k >= 2) && (k < 2 + PAIR);
      exp_cs = act ? ~(NCHIP'(1)) : '1;
      n_checks += 3;
      if (wr_n !== !(a_lo || d_lo)) begin n_fail++; $display("FAIL single_wr_n k=%0d: got %b expected %b", k, wr_n, !(a_lo || d_lo)); end
      if (cs_n !== exp_cs) begin n_fail++; $display("FAIL single_cs_n k=%0d: got %b expected %b", k, cs_n, exp_cs); end
      if (busy !== act) begin n_fail++; $display("FAIL single_busy k=%0d: got %b expected %b", k, busy, act); end
      if (a_lo || d_lo || k == 7) begin
        n_checks += 2;
        if (addr !== (d_lo || k == 7)) begin n_fail++; $display("FAIL single_addr k=%0d: got %b expected %b", k, addr, (d_lo || k == 7)); end
        if (dout !== (a_lo ? 8'h07 : 8'h38)) begin n_fail++; $display("FAIL single_dout k=%0d: got %h expected %h", k, dout, (a_lo ? 8'h07 : 8'h38)); end
      end
    end
  endtask

  task automatic test_wait();
    bit acc, found;
    logic c, last_c;
    int cnt;
    cen_per = 4;
    push_cmd(1, 8'h01, 8'h01, 5, acc);
    tick();
    cnt = 0; last_c = 1'b0; found = 0;
    for (int i = 0; i < 200; i++) begin
      c = cen;
      tick();
      if (wr_n == 1'b0) begin found = 1; break; end
      if (c) cnt++;
      last_c = c;
    end
    n_checks += 6;
    if (!found) begin n_fail++; $display("FAIL wait_timeout: got no address write expected one within 200 clocks"); end
    if (cnt != 5) begin n_fail++; $display("FAIL wait_ticks: got %0d cen ticks expected 5", cnt); end
    if (last_c !== 1'b1) begin n_fail++; $display("FAIL wait_last_tick: got %b expected 1", last_c); end
    if (cs_n !== 3'b101) begin n_fail++; $display("FAIL wait_cs_n: got %b expected 101", cs_n); end
    if (addr !== 1'b0) begin n_fail++; $display("FAIL wait_addr_a: got %b expected 0", addr); end
    if (dout !== 8'h01) begin n_fail++; $display("FAIL wait_dout_a: got %h expected 01", dout); end
    for (int i = 0; i < WR_LEN + GAP_LEN; i++) tick();
    n_checks += 3;
    if (wr_n !== 1'b0) begin n_fail++; $display("FAIL wait_wr_d: got %b expected 0", wr_n); end
    if (addr !== 1'b1) begin n_fail++; $display("FAIL wait_addr_d: got %b expected 1", addr); end
    if (dout !== 8'h01) begin n_fail++; $display("FAIL wait_dout_d: got %h expected 01", dout); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n_acc;
    obs_q.delete(); exp_q.delete();
    cen_per = 0; cen = 1'b0;
    push_cmd(2, 8'h00, 8'h1b, 3, acc);
    tick(); tick();
    n_acc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_cmd($urandom_range(0, NCHIP - 1), 8'h08 + 8'(i), 8'($urandom), 0, acc);
      if (acc) n_acc++;
      if (i == DEPTH) begin
        n_checks++;
        if (acc) begin n_fail++; $display("FAIL fill_ninth: got accepted expected refused"); end
      end
    end
    n_checks += 3;
    if (n_acc != DEPTH) begin n_fail++; $display("FAIL fill_accepted: got %0d expected %0d", n_acc, DEPTH); end
    if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", level, DEPTH); end
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", cmd_ready); end
    cen_per = 1; cen = 1'b1;
    wait_events(exp_q.size(), 400);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fill_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].chip != exp_q[i].chip || obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d) begin
          n_fail++;
          $display("FAIL fill_write[%0d]: got chip %0d addr %b data %h expected chip %0d addr %b data %h",
                   i, obs_q[i].chip, obs_q[i].a, obs_q[i].d, exp_q[i].chip, exp_q[i].a, exp_q[i].d);
        end
      end
      for (int j = 0; j < exp_q.size() / 2; j++) begin
        n_checks++;
        if (obs_q[2*j+1].cyc - obs_q[2*j].cyc != WR_LEN + GAP_LEN) begin
          n_fail++; $display("FAIL fill_ad_gap[%0d]: got %0d expected %0d", j, obs_q[2*j+1].cyc - obs_q[2*j].cyc, WR_LEN + GAP_LEN);
        end
        if (j > 0) begin
          n_checks++;
          if (obs_q[2*j].cyc - obs_q[2*j-2].cyc != PERIOD) begin
            n_fail++; $display("FAIL fill_period[%0d]: got %0d expected %0d", j, obs_q[2*j].cyc - obs_q[2*j-2].cyc, PERIOD);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_flush_wait();
    bit acc;
    obs_q.delete(); exp_q.delete();
    cen_per = 0; cen = 1'b0;
    push_cmd(0, 8'h11, 8'h22, 4, acc);
    push_cmd(1, 8'h33, 8'h44, 0, acc);
    push_cmd(2, 8'h55, 8'h66, 0, acc);
    tick();
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fwait_busy: got %b expected 1", busy); end
    if (level !== LW'(2)) begin n_fail++; $display("FAIL fwait_level_pre: got %0d expected 2", level); end
    flush = 1'b1; cmd_valid = 1'b1; cmd_chip = 2'd0; cmd_reg = 8'h77; cmd_val = 8'h77; cmd_wait = '0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fwait_ready: got %b expected 0", cmd_ready); end
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL fwait_level: got %0d expected 0", level); end
    cen_per = 1; cen = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    n_checks += 2;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL fwait_bus: got %0d writes expected 0", obs_q.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fwait_idle: got %b expected 0", busy); end
  endtask

  task automatic test_flush_gap();
    bit acc;
    obs_q.delete(); exp_q.delete();
    cen_per = 1;
    push_cmd(0, 8'h21, 8'h43, 0, acc);
    push_cmd(1, 8'h65, 8'h87, 0, acc);
    push_cmd(2, 8'ha9, 8'hcb, 0, acc);
    n_checks++;
    if (wr_n !== 1'b0 || addr !== 1'b0) begin
      n_fail++; $display("FAIL fgap_aphase: got wr_n %b addr %b expected 0 0", wr_n, addr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL fgap_level: got %0d expected 0", level); end
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fgap_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].chip != exp_q[i].chip || obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d) begin
          n_fail++;
          $display("FAIL fgap_write[%0d]: got chip %0d addr %b data %h expected chip %0d addr %b data %h",
                   i, obs_q[i].chip, obs_q[i].a, obs_q[i].d, exp_q[i].chip, exp_q[i].a, exp_q[i].d);
        end
      end
    end
  endtask

  task automatic test_err_chip();
    bit acc;
    obs_q.delete(); exp_q.delete();
    cen_per = 1;
    n_checks++;
    if (err_chip !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b expected 0", err_chip); end
    push_cmd(3, 8'h5a, 8'ha5, 0, acc);
    n_checks += 3;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL err_accept: got %b expected 1", acc); end
    if (err_chip !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_chip); end
    if (level !== '0) begin n_fail++; $display("FAIL err_level: got %0d expected 0", level); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL err_bus: got %0d writes expected 0", obs_q.size()); end
    push_cmd(1, 8'h3c, 8'hc3, 0, acc);
    for (int i = 0; i < 10; i++) tick();
    n_checks += 2;
    if (err_chip !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_chip); end
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL err_valid_after: got %0d writes expected 2", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit acc, found;
    obs_q.delete(); exp_q.delete();
    cen_per = 1;
    push_cmd(0, 8'h12, 8'h34, 0, acc);
    push_cmd(1, 8'h56, 8'h78, 0, acc);
    push_cmd(2, 8'h9a, 8'hbc, 0, acc);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_n == 1'b0 && addr == 1'b1) begin found = 1; break; end
      tick();
    end
    n_checks += 2;
    if (!found) begin n_fail++; $display("FAIL rmid_dphase: got no data write expected one within 20 clocks"); end
    if (level !== LW'(2)) begin n_fail++; $display("FAIL rmid_level_pre: got %0d expected 2", level); end
    #3 rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (wr_n !== 1'b1) begin n_fail++; $display("FAIL rmid_wr_n: got %b expected 1", wr_n); end
    if (cs_n !== '1) begin n_fail++; $display("FAIL rmid_cs_n: got %b expected all ones", cs_n); end
    if (level !== '0) begin n_fail++; $display("FAIL rmid_level: got %0d expected 0", level); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    if (addr !== 1'b0 || dout !== 8'h00) begin n_fail++; $display("FAIL rmid_bus: got addr %b dout %h expected 0 00", addr, dout); end
    if (err_chip !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b expected 0", err_chip); end
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_after: got %0d writes expected 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait();
    test_back_to_back();
    test_flush_wait();
    test_flush_gap();
    test_err_chip();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
